// File: rtl/seq_adder_64.sv
// rtl/seq_adder_64.sv - multi-cycle 64-bit adder, CHUNK bits per clock, registered carry chain
// Valid/ready on both sides; Sum and flags are held in DONE until the consumer accepts.

module seq_adder_64 #(
    parameter int CHUNK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] Sum,
    output logic        Cout,
    output logic        OF,
    output logic        ZF,
    output logic        busy
);

    localparam int NCHUNK = 64 / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [63:0]        r_a;
    logic [63:0]        r_b;
    logic [63:0]        r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_of;
    logic               r_zf;
    logic [IDXW-1:0]    r_idx;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_chunk_sum;
    logic [63:0]        w_sum_next;
    logic               w_last;

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last      = (r_idx == IDXW'(NCHUNK - 1));

    // Sum as it will look after this cycle's chunk lands; flags are taken from it.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sum_next[i*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
            r_zf    <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_chunk_sum[CHUNK];
                        r_of   <= (r_a[63] == r_b[63]) && (w_sum_next[63] != r_a[63]);
                        r_zf   <= (w_sum_next == 64'd0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign OF   = r_of;
    assign ZF   = r_zf;

endmodule

// File: tb/tb_seq_adder_64.sv
// tb/tb_seq_adder_64.sv - directed and reference-model checks of seq_adder_64 at CHUNK 16, 8, 64
// Instance 0 uses CHUNK=16, instance 1 CHUNK=8, instance 2 CHUNK=64.

module tb_seq_adder_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [3];
    logic        ir   [3];
    logic [63:0] a    [3];
    logic [63:0] b    [3];
    logic        cin  [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [63:0] sum  [3];
    logic        co   [3];
    logic        ofl  [3];
    logic        zf   [3];
    logic        bz   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    longint cyc = 0;
    longint last_acc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_adder_64 #(.CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]), .Cin(cin[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .Sum(sum[0]), .Cout(co[0]), .OF(ofl[0]), .ZF(zf[0]), .busy(bz[0]));
    seq_adder_64 #(.CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]), .Cin(cin[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .Sum(sum[1]), .Cout(co[1]), .OF(ofl[1]), .ZF(zf[1]), .busy(bz[1]));
    seq_adder_64 #(.CHUNK(64)) u_c64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]), .B(b[2]), .Cin(cin[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .Sum(sum[2]), .Cout(co[2]), .OF(ofl[2]), .ZF(zf[2]), .busy(bz[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op on instance k and stops in the first cycle out_valid is seen.
    task automatic do_op(input int k, input logic [63:0] va, input logic [63:0] vb, input logic vc,
                         input int lat, input bit chk_ivl);
        logic [64:0] ref65;
        int t;
        t = 0;
        while (!ir[k] && t < 20) begin
            tick();
            t++;
        end
        check($sformatf("k%0d ready_before_accept", k), 64'(ir[k]), 64'd1);
        iv[k] = 1'b1; a[k] = va; b[k] = vb; cin[k] = vc;
        tick();
        if (chk_ivl && last_acc[k] >= 0)
            check($sformatf("k%0d accept_spacing", k), 64'(cyc - last_acc[k]), 64'(lat + 2));
        last_acc[k] = cyc;
        iv[k] = 1'b0; a[k] = $urandom; b[k] = $urandom; cin[k] = ~vc;
        t = 0;
        while (!ov[k] && t < lat + 5) begin
            tick();
            t++;
        end
        check($sformatf("k%0d latency", k), 64'(t), 64'(lat));
        ref65 = {1'b0, va} + {1'b0, vb} + {64'd0, vc};
        check($sformatf("k%0d sum", k), sum[k], ref65[63:0]);
        check($sformatf("k%0d cout", k), 64'(co[k]), 64'(ref65[64]));
        check($sformatf("k%0d of", k), 64'(ofl[k]), 64'((va[63] == vb[63]) && (ref65[63] != va[63])));
        check($sformatf("k%0d zf", k), 64'(zf[k]), 64'(ref65[63:0] == 64'd0));
        check($sformatf("k%0d in_ready_low_done", k), 64'(ir[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; a[k] = '0; b[k] = '0; cin[k] = 1'b0; ordy[k] = 1'b1; last_acc[k] = -1;
        end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst in_ready", 64'(ir[0]), 64'd1);
        check("rst out_valid", 64'(ov[0]), 64'd0);
        check("rst busy", 64'(bz[0]), 64'd0);
        check("rst sum", sum[0], 64'd0);
        check("rst flags", {61'd0, co[0], ofl[0], zf[0]}, 64'd0);

        // Chunk ripple, watching each chunk land.
        iv[0] = 1'b1; a[0] = 64'h0000_0000_FFFF_FFFF; b[0] = 64'd0; cin[0] = 1'b1;
        tick();
        iv[0] = 1'b0; a[0] = 64'hDEAD; cin[0] = 1'b0;
        check("ripple busy", 64'(bz[0]), 64'd1);
        check("ripple in_ready", 64'(ir[0]), 64'd0);
        check("ripple sum_e0", sum[0], 64'd0);
        tick(); check("ripple sum_e1", sum[0], 64'h0000_0000_0000_0000);
        tick(); check("ripple sum_e2", sum[0], 64'h0000_0000_0000_0000);
        tick(); check("ripple sum_e3", sum[0], 64'h0000_0001_0000_0000);
        check("ripple ov_e3", 64'(ov[0]), 64'd0);
        tick(); check("ripple sum_e4", sum[0], 64'h0000_0001_0000_0000);
        check("ripple ov_e4", 64'(ov[0]), 64'd1);
        check("ripple flags", {61'd0, co[0], ofl[0], zf[0]}, 64'd0);
        tick();

        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4, 1'b0);
        check("carry sum", sum[0], 64'd0);
        check("carry cout_zf", {62'd0, co[0], zf[0]}, 64'd3);
        tick();
        do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4, 1'b0);
        check("ovf sum", sum[0], 64'h8000_0000_0000_0000);
        check("ovf of_cout", {62'd0, ofl[0], co[0]}, 64'd2);
        tick();
        do_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4, 1'b0);
        check("negovf sum", sum[0], 64'd0);
        check("negovf cout_of_zf", {61'd0, co[0], ofl[0], zf[0]}, 64'd7);
        tick();

        // Backpressure: result holds, new operands ignored.
        ordy[0] = 1'b0;
        do_op(0, 64'd100, 64'd23, 1'b0, 4, 1'b0);
        held = sum[0];
        iv[0] = 1'b1; a[0] = 64'd5; b[0] = 64'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp out_valid", 64'(ov[0]), 64'd1);
            check("bp in_ready", 64'(ir[0]), 64'd0);
            check("bp sum", sum[0], 64'd123);
        end
        ordy[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        check("bp handshake out_valid", 64'(ov[0]), 64'd0);
        check("bp handshake in_ready", 64'(ir[0]), 64'd1);
        check("bp sum_held", sum[0], held);
        do_op(0, 64'd5, 64'd6, 1'b0, 4, 1'b0);
        check("bp next sum", sum[0], 64'd11);
        tick();

        // Reset during the second RUN cycle.
        iv[0] = 1'b1; a[0] = 64'd77; b[0] = 64'd88; cin[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", 64'(ir[0]), 64'd1);
        check("midrst out_valid", 64'(ov[0]), 64'd0);
        check("midrst busy", 64'(bz[0]), 64'd0);
        check("midrst sum", sum[0], 64'd0);
        do_op(0, 64'd3, 64'd4, 1'b1, 4, 1'b0);
        check("postrst sum", sum[0], 64'd8);
        tick();

        // Back-to-back reference runs on each chunk width.
        for (int k = 0; k < 3; k++) begin
            int lat;
            lat = (k == 0) ? 4 : ((k == 1) ? 8 : 1);
            last_acc[k] = -1;
            for (int n = 0; n < 1000; n++) begin
                logic [63:0] ra, rb;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (n % 10 == 1) rb = ~ra;
                do_op(k, ra, rb, 1'($urandom), lat, 1'b1);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
